// File: rtl/ram_ctrl_pkg.sv
// Shared types and default geometry for the RAM loader/arbiter slice.
// No logic: state encoding, widths and depth only.
package ram_ctrl_pkg;
  localparam int RAM_ADDR_W    = 4;
  localparam int RAM_DATA_W    = 8;
  localparam int RAM_DEPTH     = 2**RAM_ADDR_W;
  localparam int BOOT_HOLD_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BOOT,
    RUN,
    HALTED
  } state_t;
endpackage

// File: rtl/ram_load_arbiter_if.sv
// Host byte-stream into the loader: valid/ready, one byte per accepted cycle.
// host_start opens (or reopens) a session; host_last marks the final byte.
interface ram_load_arbiter_if #(parameter int DATA_W = ram_ctrl_pkg::RAM_DATA_W);
  logic              host_start;
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_last;
  logic              host_ready;

  modport master (output host_start, host_valid, host_data, host_last, input host_ready);
  modport slave  (input host_start, host_valid, host_data, host_last, output host_ready);
endinterface

// File: rtl/ram_port_mux.sv
// Steers the single RAM port: registered loader write while ram_mode=1, else CPU pass-through.
// Purely combinational (0-cycle); CPU writes are blocked while the CPU sits in HALTED.
module ram_port_mux
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  state_t            state,
  input  logic              ram_mode,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata
);
  always_comb begin
    ram_we    = ld_we;
    ram_addr  = ld_addr;
    ram_wdata = ld_wdata;
    if (!ram_mode) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we && (state != HALTED);
    end
  end
endmodule

// File: rtl/ram_load_arbiter.sv
// Loads host bytes into RAM with the CPU held in reset, then hands the RAM port to the CPU.
// Loader writes land 1 cycle after acceptance; host_ready is high only in LOAD.
module ram_load_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int BOOT_HOLD = BOOT_HOLD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  ram_load_arbiter_if.slave host,
  input  logic              cpu_halt,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_mode,
  output logic              cpu_reset_n,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum,
  output logic              load_err,
  output logic              running
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = $clog2(BOOT_HOLD + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  boot_cnt;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              host_ready;
  logic              accept;
  logic              last_slot;
  logic              start_load;

  assign host.host_ready = host_ready;
  assign accept     = (state == LOAD) && host.host_valid;
  assign last_slot  = (load_count == (ADDR_W+1)'(DEPTH - 1));
  assign start_load = (state_nxt == LOAD) && (state != LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // BOOT spans the final write cycle plus BOOT_HOLD further cycles
  always_comb begin
    state_nxt   = state;
    host_ready  = 1'b0;
    ram_mode    = 1'b1;
    cpu_reset_n = 1'b0;
    running     = 1'b0;
    case (state)
      IDLE: if (host.host_start) state_nxt = LOAD;
      LOAD: begin
        host_ready = 1'b1;
        if (host.host_valid && (host.host_last || last_slot)) state_nxt = BOOT;
      end
      BOOT: if (boot_cnt == CNT_W'(BOOT_HOLD)) state_nxt = RUN;
      RUN: begin
        ram_mode    = 1'b0;
        cpu_reset_n = 1'b1;
        running     = 1'b1;
        if (host.host_start) state_nxt = LOAD;
        else if (cpu_halt)   state_nxt = HALTED;
      end
      HALTED: begin
        ram_mode    = 1'b0;
        cpu_reset_n = 1'b1;
        if (host.host_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      boot_cnt   <= '0;
      ld_we      <= 1'b0;
      ld_addr    <= '0;
      ld_wdata   <= '0;
      load_count <= '0;
      checksum   <= '0;
      load_err   <= 1'b0;
    end else begin
      ld_we    <= accept;
      boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
      if (accept) begin
        ld_addr    <= ptr;
        ld_wdata   <= host.host_data;
        ptr        <= ptr + 1'b1;
        load_count <= (load_count == (ADDR_W+1)'(DEPTH)) ? load_count : load_count + 1'b1;
        checksum   <= checksum + host.host_data;
        if (last_slot && !host.host_last) load_err <= 1'b1;
      end
      if (start_load) begin
        ptr        <= '0;
        load_count <= '0;
        checksum   <= '0;
        load_err   <= 1'b0;
      end
    end
  end

  ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .state     (state),
    .ram_mode  (ram_mode),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata)
  );
endmodule

// File: tb/tb_ram_load_arbiter.sv
// Randomized bench for ram_load_arbiter: sessions are scored against a transaction-level model
// (expected write list, count, checksum, error flag, boot timing).
module tb_ram_load_arbiter;
  import ram_ctrl_pkg::*;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_load_arbiter_if #(.DATA_W(DW)) hif ();

  logic          cpu_halt, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_mode, cpu_reset_n, load_err, running;
  logic [AW:0]   load_count;
  logic [DW-1:0] checksum;

  ram_load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BOOT_HOLD(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (hif),
    .cpu_halt    (cpu_halt),
    .cpu_addr    (cpu_addr),
    .cpu_we      (cpu_we),
    .cpu_wdata   (cpu_wdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_mode    (ram_mode),
    .cpu_reset_n (cpu_reset_n),
    .load_count  (load_count),
    .checksum    (checksum),
    .load_err    (load_err),
    .running     (running)
  );

  typedef struct {
    int            t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  logic [DW-1:0] tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Loader writes as seen on the RAM port, stamped with the cycle they occupy
  always @(negedge clk) begin
    if (reset && ram_mode && ram_we) obs_q.push_back('{cyc, ram_addr, ram_wdata});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ram_we"}, ram_we, 0);
    check_val({tag, "_ram_addr"}, ram_addr, 0);
    check_val({tag, "_ram_wdata"}, ram_wdata, 0);
    check_val({tag, "_ram_mode"}, ram_mode, 1);
    check_val({tag, "_cpu_reset_n"}, cpu_reset_n, 0);
    check_val({tag, "_host_ready"}, hif.host_ready, 0);
    check_val({tag, "_load_count"}, load_count, 0);
    check_val({tag, "_checksum"}, checksum, 0);
    check_val({tag, "_load_err"}, load_err, 0);
    check_val({tag, "_running"}, running, 0);
  endtask

  // mode: 0 back-to-back, 1 one bubble before every byte, 2 random bubbles
  task automatic load_session(input int mode, input bit with_last, input bit halt_too);
    int n;
    int sum;
    int gaps;
    n   = tx_q.size();
    sum = 0;
    obs_q.delete();
    exp_q.delete();
    hif.host_start = 1'b1;
    if (halt_too) begin
      cpu_halt = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'h5C;
      #1;
      check_val("preempt_cpu_write_passes", ram_we, 1);
    end
    step();
    hif.host_start = 1'b0;
    cpu_halt = 1'b0;
    cpu_we   = 1'b0;
    check_val("load_ready", hif.host_ready, 1);
    check_val("load_cpu_reset_n", cpu_reset_n, 0);
    check_val("load_ram_mode", ram_mode, 1);
    check_val("load_count_clr", load_count, 0);
    check_val("load_checksum_clr", checksum, 0);
    check_val("load_running", running, 0);
    for (int i = 0; i < n; i++) begin
      gaps = (mode == 1) ? 1 : ((mode == 2) ? int'($urandom_range(0, 3)) : 0);
      hif.host_valid = 1'b0;
      repeat (gaps) begin
        hif.host_data  = DW'($urandom);
        hif.host_last  = 1'($urandom);
        hif.host_start = 1'($urandom);
        step();
      end
      hif.host_start = 1'b0;
      hif.host_valid = 1'b1;
      hif.host_data  = tx_q[i];
      hif.host_last  = with_last && (i == n - 1);
      exp_q.push_back('{cyc + 1, AW'(i), tx_q[i]});
      sum += int'(tx_q[i]);
      step();
    end
    hif.host_valid = 1'b0;
    hif.host_last  = 1'b0;
    check_val("boot_ready_low", hif.host_ready, 0);
    check_val("boot_not_running", running, 0);
    for (int k = 1; k <= HOLD + 1; k++) begin
      step();
      check_val("boot_cpu_reset_n", cpu_reset_n, (k == HOLD + 1) ? 1 : 0);
    end
    check_val("run_running", running, 1);
    check_val("run_ram_mode", ram_mode, 0);
    check_val("sess_load_count", load_count, n);
    check_val("sess_checksum", checksum, sum & 8'hFF);
    check_val("sess_load_err", load_err, (n == RAM_DEPTH && !with_last) ? 1 : 0);
    check_val("sess_write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_val("wr_cycle", obs_q[i].t, exp_q[i].t);
      check_val("wr_addr", obs_q[i].a, exp_q[i].a);
      check_val("wr_data", obs_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic random_tx(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(DW'($urandom));
  endtask

  initial begin
    int n;
    hif.host_start = 1'b0; hif.host_valid = 1'b0; hif.host_data = '0; hif.host_last = 1'b0;
    cpu_halt = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #12;
    check_reset_vals("por");
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    check_val("idle_ready", hif.host_ready, 0);
    check_val("idle_ram_mode", ram_mode, 1);

    tx_q = '{8'h79, 8'h30, 8'h10};
    load_session(0, 1'b1, 1'b0);
    check_val("t1_checksum_b9", checksum, 8'hB9);

    // CPU pass-through in RUN, then HALTED write gate
    cpu_addr = 4'hA; cpu_we = 1'b1; cpu_wdata = 8'h08;
    #1;
    check_val("run_addr_a", ram_addr, 4'hA);
    check_val("run_we", ram_we, 1);
    check_val("run_wdata_08", ram_wdata, 8'h08);
    for (int i = 0; i < 6; i++) begin
      step();
      cpu_addr = AW'($urandom); cpu_we = 1'($urandom); cpu_wdata = DW'($urandom);
      #1;
      check_val("run_pass_addr", ram_addr, cpu_addr);
      check_val("run_pass_we", ram_we, cpu_we);
      check_val("run_pass_wdata", ram_wdata, cpu_wdata);
    end
    cpu_we = 1'b1; cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    repeat (2) begin
      check_val("halt_running", running, 0);
      check_val("halt_cpu_reset_n", cpu_reset_n, 1);
      check_val("halt_ram_mode", ram_mode, 0);
      check_val("halt_we_gated", ram_we, 0);
      check_val("halt_addr_pass", ram_addr, cpu_addr);
      step();
    end

    tx_q.delete();
    for (int i = 1; i <= 16; i++) tx_q.push_back(DW'(i));
    load_session(0, 1'b0, 1'b0);
    check_val("t2_checksum_88", checksum, 8'h88);
    check_val("t2_load_err", load_err, 1);

    random_tx($urandom_range(4, 10));
    load_session(1, 1'b1, 1'b0);

    for (int s = 0; s < 4; s++) begin
      n = $urandom_range(1, 16);
      random_tx(n);
      load_session(2, (n < 16) ? 1'b1 : 1'($urandom), 1'b0);
    end

    random_tx($urandom_range(1, 8));
    load_session(0, 1'b1, 1'b1);

    // Async reset in the middle of a load
    hif.host_start = 1'b1;
    step();
    hif.host_start = 1'b0;
    hif.host_valid = 1'b1; hif.host_data = 8'h5A;
    step();
    hif.host_data = 8'hC3;
    step();
    hif.host_valid = 1'b0;
    check_val("abort_pre_count", load_count, 2);
    reset = 1'b0;
    #1;
    check_reset_vals("abort");
    @(posedge clk);
    #1 reset = 1'b1;
    obs_q.delete();
    step();
    random_tx($urandom_range(2, 6));
    load_session(2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
